sysid_boot_checker: RTL

Boot-time controller for the system-ID peripheral. After reset it reads the ID word (address 0) and the timestamp word (address 1). It compares both against the values expected at build time and retries on mismatch, then reports pass or fail. It is the single owner of the sysid slave: it arbitrates between its own check sequence and a CPU-side read port, and stalls the CPU port while a check is running.

---
 rtl/sysid_boot_checker_pkg.sv | 29 ++
 rtl/sysid_boot_checker_if.sv | 24 ++
 rtl/sysid_boot_checker_gap_timer.sv | 35 +++
 rtl/sysid_boot_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the sysid boot checker.
package sysid_boot_checker_pkg;

  localparam int unsigned ATTEMPTS_W = 3;

  localparam logic SID_ADDR_ID = 1'b0;
  localparam logic SID_ADDR_TS = 1'b1;

  typedef enum logic [3:0] {
    ST_ID_SETUP,
    ST_ID_CAP,
    ST_TS_SETUP,
    ST_TS_CAP,
    ST_COMPARE,
    ST_GAP,
    ST_IDLE,
    ST_CPU_SETUP,
    ST_CPU_CAP
  } state_e;

  // Saturating increment so the attempt counter never wraps past its limit.
  function automatic logic [ATTEMPTS_W-1:0] sat_inc(
    input logic [ATTEMPTS_W-1:0] val,
    input logic [ATTEMPTS_W-1:0] lim
  );
    return (val >= lim) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// CPU-side read port of the sysid boot checker (Avalon-MM style, one read outstanding).
interface sysid_boot_checker_if;
  logic        cpu_read;
  logic        cpu_address;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;

  modport master (
    output cpu_read,
    output cpu_address,
    input  cpu_waitrequest,
    input  cpu_readdata,
    input  cpu_readdatavalid
  );

  modport slave (
    input  cpu_read,
    input  cpu_address,
    output cpu_waitrequest,
    output cpu_readdata,
    output cpu_readdatavalid
  );
endinterface

// File: rtl/sysid_boot_checker_gap_timer.sv
// Loadable down-counter timing the idle gap between failed check attempts.
module sysid_boot_checker_gap_timer #(
  parameter int unsigned LOAD_VAL = 15,
  localparam int unsigned CNT_W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic count_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid check with retry and a stalled CPU read port sharing the sysid slave.
// Retry/GAP support is built only when SYSID_BOOT_CHECKER_RETRY_EN is defined.
module sysid_boot_checker
  import sysid_boot_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'd0,
  parameter logic [31:0] EXPECTED_TS = 32'd1513073316,
  parameter int unsigned RETRY_MAX   = 3,
  parameter int unsigned POLL_GAP    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  sysid_boot_checker_if.slave   cpu,
  output logic                  sid_address_o,
  input  logic [31:0]           sid_readdata_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  id_mismatch_o,
  output logic                  ts_mismatch_o,
  output logic [ATTEMPTS_W-1:0] attempts_o
);

`ifdef SYSID_BOOT_CHECKER_RETRY_EN
  localparam logic [ATTEMPTS_W-1:0] MAX_ATT = ATTEMPTS_W'(RETRY_MAX);
`else
  localparam logic [ATTEMPTS_W-1:0] MAX_ATT = ATTEMPTS_W'(1);
`endif

  state_e                state_q, state_d;
  logic [31:0]           id_q, id_d;
  logic [31:0]           ts_q, ts_d;
  logic [ATTEMPTS_W-1:0] attempts_q, attempts_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  id_mm_q, id_mm_d;
  logic                  ts_mm_q, ts_mm_d;
  logic                  sid_addr_q, sid_addr_d;
  logic                  cpu_addr_q, cpu_addr_d;
  logic                  start_pending_q, start_pending_d;
  logic                  gap_zero;
  logic                  id_bad, ts_bad;

  assign id_bad = (id_q != EXPECTED_ID);
  assign ts_bad = (ts_q != EXPECTED_TS);

`ifdef SYSID_BOOT_CHECKER_RETRY_EN
  logic gap_load;
  logic gap_count;

  assign gap_load  = (state_q == ST_COMPARE) && (state_d == ST_GAP);
  assign gap_count = (state_q == ST_GAP);

  sysid_boot_checker_gap_timer #(
    .LOAD_VAL(POLL_GAP - 1)
  ) u_gap_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (gap_load),
    .count_i(gap_count),
    .zero_o (gap_zero)
  );
`else
  assign gap_zero = 1'b1;
`endif

  always_comb begin
    state_d         = state_q;
    id_d            = id_q;
    ts_d            = ts_q;
    attempts_d      = attempts_q;
    done_d          = done_q;
    pass_d          = pass_q;
    id_mm_d         = id_mm_q;
    ts_mm_d         = ts_mm_q;
    sid_addr_d      = sid_addr_q;
    cpu_addr_d      = cpu_addr_q;
    start_pending_d = start_pending_q;

    unique case (state_q)
      ST_ID_SETUP: begin
        sid_addr_d = SID_ADDR_ID;
        attempts_d = sat_inc(attempts_q, MAX_ATT);
        state_d    = ST_ID_CAP;
      end
      ST_ID_CAP: begin
        id_d    = sid_readdata_i;
        state_d = ST_TS_SETUP;
      end
      ST_TS_SETUP: begin
        sid_addr_d = SID_ADDR_TS;
        state_d    = ST_TS_CAP;
      end
      ST_TS_CAP: begin
        ts_d    = sid_readdata_i;
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        id_mm_d = id_bad;
        ts_mm_d = ts_bad;
        if (!id_bad && !ts_bad) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (attempts_q < MAX_ATT) begin
          state_d = ST_GAP;
        end else begin
          pass_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_d = ST_ID_SETUP;
        end
      end
      ST_IDLE: begin
        // A queued or fresh start beats a simultaneous CPU read.
        if (start_pending_q || start_i) begin
          start_pending_d = 1'b0;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          id_mm_d         = 1'b0;
          ts_mm_d         = 1'b0;
          attempts_d      = '0;
          state_d         = ST_ID_SETUP;
        end else if (cpu.cpu_read) begin
          cpu_addr_d = cpu.cpu_address;
          state_d    = ST_CPU_SETUP;
        end
      end
      ST_CPU_SETUP: begin
        sid_addr_d = cpu_addr_q;
        if (start_i) begin
          start_pending_d = 1'b1;
        end
        state_d = ST_CPU_CAP;
      end
      ST_CPU_CAP: begin
        if (start_i) begin
          start_pending_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_ID_SETUP;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_ID_SETUP;
      id_q            <= '0;
      ts_q            <= '0;
      attempts_q      <= '0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      id_mm_q         <= 1'b0;
      ts_mm_q         <= 1'b0;
      sid_addr_q      <= SID_ADDR_ID;
      cpu_addr_q      <= 1'b0;
      start_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      id_q            <= id_d;
      ts_q            <= ts_d;
      attempts_q      <= attempts_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      id_mm_q         <= id_mm_d;
      ts_mm_q         <= ts_mm_d;
      sid_addr_q      <= sid_addr_d;
      cpu_addr_q      <= cpu_addr_d;
      start_pending_q <= start_pending_d;
    end
  end

  // Read data is passed through combinationally in CPU_CAP so it lands two cycles after acceptance.
  assign cpu.cpu_waitrequest   = !((state_q == ST_IDLE) && !start_pending_q && !start_i);
  assign cpu.cpu_readdatavalid = (state_q == ST_CPU_CAP);
  assign cpu.cpu_readdata      = (state_q == ST_CPU_CAP) ? sid_readdata_i : '0;

  assign sid_address_o = sid_addr_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign id_mismatch_o = id_mm_q;
  assign ts_mismatch_o = ts_mm_q;
  assign attempts_o    = attempts_q;

endmodule
